pc_sequencer: RTL and testbench

Multi-cycle fetch/execute sequencer that drives the `pc` register's load and increment controls.
- Runs instruction fetch against instruction memory, then waits for the datapath to finish execute.
- Resolves the next PC: sequential, branch, jump, jump-register, interrupt return or interrupt vector.
- Holds the exception PC (EPC) and the interrupt-enable flag.
- Sits between the control unit's decode outputs, instruction memory and the `pc` register.

---
 rtl/pc_sequencer_pkg.sv | 17 +
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_sequencer_npc_mux.sv | 40 ++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch/execute PC sequencer.
// State encodings are 2-bit; INT_VECTOR_DEFAULT is the reset-free handler address.
package pc_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int JMP_W  = 26;

    localparam logic [DATA_W-1:0] INT_VECTOR_DEFAULT = 32'h0000_03FC;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of decode, memory handshake and PC-register signals around the sequencer.
// master = sequencer side, slave = control unit / memory / pc register side.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic              mem_rdy;
    logic              ex_done;
    logic              ir_break;
    logic              ir_reti;
    logic              ir_jr;
    logic              ir_jump;
    logic              ir_branch;
    logic              br_taken;
    logic [DATA_W-1:0] br_offset;
    logic [JMP_W-1:0]  jmp_target;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] pc_out;
    logic              intr;

    logic              mem_rd;
    logic              ir_ld;
    logic              pc_ld;
    logic              pc_inc;
    logic [DATA_W-1:0] pc_in;
    logic              int_ack;
    logic [DATA_W-1:0] epc;
    logic              int_en;
    logic              halted;

    modport master (
        input  mem_rdy, ex_done, ir_break, ir_reti, ir_jr, ir_jump, ir_branch,
               br_taken, br_offset, jmp_target, rs_data, pc_out, intr,
        output mem_rd, ir_ld, pc_ld, pc_inc, pc_in, int_ack, epc, int_en, halted
    );

    modport slave (
        output mem_rdy, ex_done, ir_break, ir_reti, ir_jr, ir_jump, ir_branch,
               br_taken, br_offset, jmp_target, rs_data, pc_out, intr,
        input  mem_rd, ir_ld, pc_ld, pc_inc, pc_in, int_ack, epc, int_en, halted
    );

endinterface

// File: rtl/pc_sequencer_npc_mux.sv
// Next-PC priority select: reti > jr > jump > taken branch > sequential.
// npc_is_seq flags the fall-through case, where pc_out already holds PC+4.
module npc_mux
    import pc_sequencer_pkg::*;
(
    input  logic                     ir_reti,
    input  logic                     ir_jr,
    input  logic                     ir_jump,
    input  logic                     ir_branch,
    input  logic                     br_taken,
    input  logic        [DATA_W-1:0] pc_out,
    input  logic        [DATA_W-1:0] epc,
    input  logic        [DATA_W-1:0] rs_data,
    input  logic signed [DATA_W-1:0] br_offset,
    input  logic        [JMP_W-1:0]  jmp_target,
    output logic        [DATA_W-1:0] npc,
    output logic                     npc_is_seq
);

    // Word offset to byte displacement; the add wraps modulo 2^32.
    logic signed [DATA_W-1:0] br_disp;
    assign br_disp = br_offset <<< 2;

    always_comb begin
        npc        = pc_out;
        npc_is_seq = 1'b0;
        if (ir_reti) begin
            npc = epc;
        end else if (ir_jr) begin
            npc = rs_data;
        end else if (ir_jump) begin
            npc = {pc_out[31:28], jmp_target, 2'b00};
        end else if (ir_branch && br_taken) begin
            npc = pc_out + $unsigned(br_disp);
        end else begin
            npc_is_seq = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the pc register strobes,
// holding EPC and the interrupt-enable flag.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [DATA_W-1:0] INT_VECTOR = INT_VECTOR_DEFAULT
)(
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic              int_en_q, int_en_d;
    logic              halted_q, halted_d;

    logic [DATA_W-1:0] npc;
    logic              npc_is_seq;

    logic              mem_rd, ir_ld, pc_ld, pc_inc, int_ack;
    logic [DATA_W-1:0] pc_in;
    logic              take_int;

    npc_mux u_npc_mux (
        .ir_reti    (bus.ir_reti),
        .ir_jr      (bus.ir_jr),
        .ir_jump    (bus.ir_jump),
        .ir_branch  (bus.ir_branch),
        .br_taken   (bus.br_taken),
        .pc_out     (bus.pc_out),
        .epc        (epc_q),
        .rs_data    (bus.rs_data),
        .br_offset  (bus.br_offset),
        .jmp_target (bus.jmp_target),
        .npc        (npc),
        .npc_is_seq (npc_is_seq)
    );

    // Uses the registered int_en, so a reti cannot be interrupted by its own re-enable.
    assign take_int = bus.intr && int_en_q;

    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        int_en_d = int_en_q;
        mem_rd   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        pc_in    = '0;
        int_ack  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_rdy) begin
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = bus.ir_break ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.ex_done) begin
                    state_d = ST_FETCH;
                    if (bus.ir_reti) int_en_d = 1'b1;
                    if (take_int) begin
                        epc_d    = npc;
                        pc_ld    = 1'b1;
                        pc_in    = INT_VECTOR;
                        int_ack  = 1'b1;
                        int_en_d = 1'b0;
                    end else if (!npc_is_seq) begin
                        pc_ld = 1'b1;
                        pc_in = npc;
                    end
                end
            end
            ST_HALT: begin
                if (take_int) begin
                    epc_d    = bus.pc_out;
                    pc_ld    = 1'b1;
                    pc_in    = INT_VECTOR;
                    int_ack  = 1'b1;
                    int_en_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            epc_q    <= '0;
            int_en_q <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            int_en_q <= int_en_d;
            halted_q <= halted_d;
        end
    end

    // Reset suppresses every strobe so a pending load/increment is discarded.
    assign bus.mem_rd  = mem_rd  && !reset;
    assign bus.ir_ld   = ir_ld   && !reset;
    assign bus.pc_inc  = pc_inc  && !reset;
    assign bus.pc_ld   = pc_ld   && !reset;
    assign bus.pc_in   = reset ? '0 : pc_in;
    assign bus.int_ack = int_ack && !reset;
    assign bus.epc     = epc_q;
    assign bus.int_en  = int_en_q;
    assign bus.halted  = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural pc register attached;
// the bench can overwrite the pc register to place pc_out at chosen values.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        pc_wr;
    logic [31:0] pc_wr_val;
    logic [31:0] pc_q;
    int          checks;
    int          errors;

    pc_sequencer_if sif ();

    pc_sequencer #(.INT_VECTOR(32'h0000_03FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset)            pc_q <= 32'h0;
        else if (pc_wr)       pc_q <= pc_wr_val;
        else if (sif.pc_ld)   pc_q <= sif.pc_in;
        else if (sif.pc_inc)  pc_q <= pc_q + 32'd4;
    end
    assign sif.pc_out = pc_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // From FETCH: fetch, decode (placing pc_out at v), stop at the start of EXEC.
    task automatic run_to_exec(input logic [31:0] v);
        @(negedge clk); sif.mem_rdy = 1'b1; sif.ex_done = 1'b0;
        @(negedge clk); sif.mem_rdy = 1'b0; pc_wr = 1'b1; pc_wr_val = v;
        @(negedge clk); pc_wr = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; pc_wr = 1'b0; pc_wr_val = '0;
        sif.mem_rdy = 0; sif.ex_done = 0; sif.ir_break = 0; sif.ir_reti = 0;
        sif.ir_jr = 0; sif.ir_jump = 0; sif.ir_branch = 0; sif.br_taken = 0;
        sif.br_offset = '0; sif.jmp_target = '0; sif.rs_data = '0; sif.intr = 0;

        repeat (2) @(negedge clk);
        sif.mem_rdy = 1'b1; sif.ex_done = 1'b1;
        #1;
        chk("rst_pc_inc", sif.pc_inc, 0);
        chk("rst_ir_ld", sif.ir_ld, 0);
        chk("rst_pc_ld", sif.pc_ld, 0);
        chk("rst_epc", sif.epc, 0);
        chk("rst_int_en", sif.int_en, 1);
        chk("rst_halted", sif.halted, 0);

        // Sequential flow: pc_inc every third cycle.
        @(negedge clk); reset = 1'b0; #1;
        chk("seq_mem_rd", sif.mem_rd, 1);
        chk("seq_inc0", sif.pc_inc, 1);
        chk("seq_ir_ld", sif.ir_ld, 1);
        chk("seq_pc0", sif.pc_out, 32'h0);
        @(negedge clk); #1;
        chk("seq_dec_inc", sif.pc_inc, 0);
        chk("seq_dec_mem_rd", sif.mem_rd, 0);
        chk("seq_pc4", sif.pc_out, 32'h4);
        @(negedge clk); #1;
        chk("seq_ex_ld", sif.pc_ld, 0);
        chk("seq_ex_inc", sif.pc_inc, 0);
        @(negedge clk); #1;
        chk("seq_inc1", sif.pc_inc, 1);
        repeat (3) @(negedge clk);
        sif.mem_rdy = 1'b0; #1;
        chk("seq_pc8", sif.pc_out, 32'h8);

        // Fetch stall, with a stray ex_done that must be ignored.
        sif.ex_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_mem_rd", sif.mem_rd, 1);
            chk("stall_ir_ld", sif.ir_ld, 0);
            chk("stall_pc_ld", sif.pc_ld, 0);
            @(negedge clk);
        end
        sif.ex_done = 1'b0;

        // Branch with negative offset wrapping below zero.
        sif.ir_branch = 1; sif.br_taken = 1; sif.br_offset = 32'hFFFF_FFFE;
        run_to_exec(32'h4);
        sif.ex_done = 1'b1; #1;
        chk("br_pc_ld", sif.pc_ld, 1);
        chk("br_pc_in", sif.pc_in, 32'hFFFF_FFFC);
        chk("br_pc_inc", sif.pc_inc, 0);
        sif.br_taken = 0;
        run_to_exec(32'h4);
        sif.ex_done = 1'b1; #1;
        chk("brnt_pc_ld", sif.pc_ld, 0);
        chk("brnt_pc_in", sif.pc_in, 0);
        sif.ir_branch = 0;

        // jr outranks jump.
        sif.ir_jump = 1; sif.ir_jr = 1; sif.rs_data = 32'h0000_1000;
        run_to_exec(32'h8);
        sif.ex_done = 1'b1; #1;
        chk("jr_pc_in", sif.pc_in, 32'h0000_1000);
        chk("jr_pc_ld", sif.pc_ld, 1);
        sif.ir_jr = 0; sif.jmp_target = 26'h0000010;
        run_to_exec(32'h4000_0008);
        sif.ex_done = 1'b1; #1;
        chk("jmp_pc_in", sif.pc_in, 32'h4000_0040);
        sif.ir_jump = 0;

        // Interrupt at the end of a sequential instruction.
        run_to_exec(32'h20);
        sif.intr = 1'b1; sif.ex_done = 1'b1; #1;
        chk("irq_ack", sif.int_ack, 1);
        chk("irq_pc_ld", sif.pc_ld, 1);
        chk("irq_pc_in", sif.pc_in, 32'h3FC);
        @(negedge clk); sif.ex_done = 1'b0; #1;
        chk("irq_ack_once", sif.int_ack, 0);
        chk("irq_epc", sif.epc, 32'h20);
        chk("irq_int_en", sif.int_en, 0);

        // reti with intr still high: return to EPC, no nested acknowledge.
        sif.ir_reti = 1'b1;
        run_to_exec(32'h400);
        sif.ex_done = 1'b1; #1;
        chk("reti_pc_in", sif.pc_in, 32'h20);
        chk("reti_pc_ld", sif.pc_ld, 1);
        chk("reti_no_ack", sif.int_ack, 0);
        @(negedge clk); sif.ex_done = 1'b0; sif.intr = 1'b0; sif.ir_reti = 1'b0; #1;
        chk("reti_int_en", sif.int_en, 1);
        chk("reti_epc", sif.epc, 32'h20);

        // break -> HALT, interrupt exit while enabled.
        sif.ir_break = 1'b1;
        run_to_exec(32'h100);
        #1;
        chk("halt_flag", sif.halted, 1);
        chk("halt_pc_ld", sif.pc_ld, 0);
        @(negedge clk); #1;
        chk("halt_stay", sif.halted, 1);
        @(negedge clk); sif.intr = 1'b1; #1;
        chk("halt_irq_ack", sif.int_ack, 1);
        chk("halt_irq_pc_in", sif.pc_in, 32'h3FC);
        @(negedge clk); sif.intr = 1'b0; #1;
        chk("halt_exit", sif.halted, 0);
        chk("halt_exit_mem_rd", sif.mem_rd, 1);
        chk("halt_epc", sif.epc, 32'h100);
        chk("halt_int_en", sif.int_en, 0);

        // HALT with interrupts disabled stays halted.
        run_to_exec(32'h200);
        sif.intr = 1'b1; #1;
        chk("halt_dis_ack", sif.int_ack, 0);
        chk("halt_dis_pc_ld", sif.pc_ld, 0);
        @(negedge clk); #1;
        chk("halt_dis_stay", sif.halted, 1);
        @(negedge clk); reset = 1'b1; sif.intr = 1'b0; sif.ir_break = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        chk("unhalt_rst", sif.halted, 0);
        chk("unhalt_int_en", sif.int_en, 1);

        // Reset in EXEC with ex_done and a pending interrupt.
        sif.ir_jump = 1'b1;
        run_to_exec(32'h50);
        reset = 1'b1; sif.ex_done = 1'b1; sif.intr = 1'b1; #1;
        chk("rstx_pc_ld", sif.pc_ld, 0);
        chk("rstx_ack", sif.int_ack, 0);
        @(negedge clk); reset = 1'b0; sif.ex_done = 1'b0; sif.intr = 1'b0; #1;
        chk("rstx_mem_rd", sif.mem_rd, 1);
        chk("rstx_epc", sif.epc, 0);
        chk("rstx_int_en", sif.int_en, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
